// File: rtl/y86_regs_pkg.sv
// Shared register-file definitions for the pipelined Y86 core: index names,
// the "no register" code and the dump engine state encoding.
package y86_regs_pkg;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0] RRAX = 4'd0;
    localparam logic [3:0] RRCX = 4'd1;
    localparam logic [3:0] RRDX = 4'd2;
    localparam logic [3:0] RRBX = 4'd3;
    localparam logic [3:0] RRSP = 4'd4;
    localparam logic [3:0] RRBP = 4'd5;
    localparam logic [3:0] RRSI = 4'd6;
    localparam logic [3:0] RRDI = 4'd7;
    localparam logic [3:0] R8   = 4'd8;
    localparam logic [3:0] R9   = 4'd9;
    localparam logic [3:0] R10  = 4'd10;
    localparam logic [3:0] R11  = 4'd11;
    localparam logic [3:0] R12  = 4'd12;
    localparam logic [3:0] R13  = 4'd13;
    localparam logic [3:0] R14  = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Serial register dump engine: walks indices 0..NREGS-1, one beat per transfer.
// Latency: first beat valid the cycle after dump_req; beat held while dump_ready is low.
// Backpressure: valid/ready; data is a live array read so it tracks writes while stalled.
module regfile_dump_fsm
    import y86_regs_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (dump_ready) begin
                        if (idx == LAST_IDX) state <= DONE;
                        else                 idx   <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset drops them without an edge.
    assign dump_valid = (state == SCAN);
    assign dump_busy  = (state != IDLE);
    assign dump_done  = (state == DONE);
    assign dump_idx   = idx;
    assign rd_idx     = idx;
    assign dump_data  = rd_data;

endmodule

// File: rtl/regfile_pipe.sv
// Y86 register file: two combinational read ports with write-back bypass, E/M write ports.
// Latency: reads 0 cycles, writes 1 edge (bypassed in the write cycle); dump via valid/ready.
// Backpressure: only the dump port stalls; read/write ports never stall.
module regfile_pipe
    import y86_regs_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                NREGS    = 15,
    parameter int                ADDR_W   = 4,
    parameter int                SP_IDX   = 4,
    parameter logic [DATA_W-1:0] SP_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam logic [ADDR_W:0]   NREGS_W  = (ADDR_W + 1)'(NREGS);
    localparam logic [ADDR_W-1:0] IDX_NONE = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] regs [NREGS];
    logic              e_ok;
    logic              m_ok;
    logic              we_e;
    logic [ADDR_W-1:0] dump_rd_idx;
    logic [DATA_W-1:0] dump_rd_data;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return (idx != IDX_NONE) && ({1'b0, idx} < NREGS_W);
    endfunction

    assign e_ok = idx_ok(dstE);
    assign m_ok = idx_ok(dstM);
    // M wins an E/M collision; the E write is dropped entirely.
    assign we_e = e_ok && !(m_ok && (dstM == dstE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            if (we_e) regs[dstE] <= valE;
            if (m_ok) regs[dstM] <= valM;
        end
    end

    always_comb begin
        valA = '0;
        if (idx_ok(srcA)) begin
            if (m_ok && (srcA == dstM))      valA = valM;
            else if (e_ok && (srcA == dstE)) valA = valE;
            else                             valA = regs[srcA];
        end
    end

    always_comb begin
        valB = '0;
        if (idx_ok(srcB)) begin
            if (m_ok && (srcB == dstM))      valB = valM;
            else if (e_ok && (srcB == dstE)) valB = valE;
            else                             valB = regs[srcB];
        end
    end

    // Dump reads the stored array only; no bypass on this path.
    assign dump_rd_data = idx_ok(dump_rd_idx) ? regs[dump_rd_idx] : '0;

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .rd_idx     (dump_rd_idx),
        .rd_data    (dump_rd_data)
    );

endmodule

// File: tb/tb_regfile_pipe.sv
// Self-checking bench for regfile_pipe against an array-based reference model.
module tb_regfile_pipe;

    localparam logic [63:0] SPR = 64'h200;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, valE, valM;
    logic        dump_req, dump_ready;
    logic        dump_valid, dump_busy, dump_done;
    logic [3:0]  dump_idx;
    logic [63:0] dump_data;

    int checks   = 0;
    int failures = 0;

    logic [63:0] model [15];

    regfile_pipe #(
        .DATA_W   (64),
        .NREGS    (15),
        .ADDR_W   (4),
        .SP_IDX   (4),
        .SP_RESET (SPR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .srcA       (srcA),
        .srcB       (srcB),
        .valA       (valA),
        .valB       (valB),
        .dstE       (dstE),
        .valE       (valE),
        .dstM       (dstM),
        .valM       (valM),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 15; i++) model[i] = (i == 4) ? SPR : 64'h0;
    endfunction

    function automatic logic [63:0] ref_read(input logic [3:0] s);
        if (s >= 4'd15) return 64'h0;
        if (dstM < 4'd15 && s == dstM) return valM;
        if (dstE < 4'd15 && s == dstE) return valE;
        return model[s];
    endfunction

    // Applies the write-back of the current cycle: E first, then M overrides.
    function automatic void model_write();
        if (dstE < 4'd15) model[dstE] = valE;
        if (dstM < 4'd15) model[dstM] = valM;
    endfunction

    task automatic idle_ports();
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
    endtask

    // Runs one full dump; ready either toggles 1,0,1,... or is held high.
    task automatic run_dump(input bit toggle, input string tag);
        int          beats = 0;
        int          dones = 0;
        bit          prev_stall = 0;
        logic [3:0]  prev_idx = '0;
        logic [63:0] prev_data = '0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        checks++;
        if (dump_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid_rise got=%b want=1", tag, dump_valid);
        end
        for (int c = 0; c < 120; c++) begin
            dump_ready = toggle ? (c % 2 == 0) : 1'b1;
            dump_req   = (c == 3);
            #4;
            if (dump_valid) begin
                checks++;
                if (dump_data !== model[dump_idx]) begin
                    failures++;
                    $display("FAIL %s_data idx=%0d got=%h want=%h", tag, dump_idx, dump_data, model[dump_idx]);
                end
                if (prev_stall) begin
                    checks++;
                    if (dump_idx !== prev_idx || dump_data !== prev_data) begin
                        failures++;
                        $display("FAIL %s_hold got=%0d/%h want=%0d/%h", tag, dump_idx, dump_data, prev_idx, prev_data);
                    end
                end
                if (dump_ready) begin
                    checks++;
                    if (dump_idx !== 4'(beats)) begin
                        failures++;
                        $display("FAIL %s_order got=%0d want=%0d", tag, dump_idx, beats);
                    end
                    beats++;
                end
            end
            if (dump_done) dones++;
            prev_stall = dump_valid && !dump_ready;
            prev_idx   = dump_idx;
            prev_data  = dump_data;
            tick();
            if (dones > 0 && !dump_done && !dump_busy) break;
        end
        dump_req = 1'b0; dump_ready = 1'b0;
        checks++;
        if (beats != 15) begin
            failures++;
            $display("FAIL %s_beats got=%0d want=15", tag, beats);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL %s_done_pulses got=%0d want=1", tag, dones);
        end
        checks++;
        if (dump_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_end got=%b want=0", tag, dump_busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_dump got=v%b b%b d%b i%0d want=0000", dump_valid, dump_busy, dump_done, dump_idx);
        end
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i);
            srcB = 4'(15 - i);
            #1;
            checks++;
            if (valA !== ref_read(srcA) || valB !== ref_read(srcB)) begin
                failures++;
                $display("FAIL reset_read a=%0d got=%h/%h want=%h/%h", i, valA, valB, ref_read(srcA), ref_read(srcB));
            end
        end
    endtask

    task automatic test_bypass();
        dstE = 4'd3; valE = 64'h1122; srcA = 4'd3;
        #4;
        checks++;
        if (valA !== 64'h1122) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h want=1122", valA);
        end
        model_write();
        tick();
        dstE = 4'hF;
        #4;
        checks++;
        if (valA !== 64'h1122) begin
            failures++;
            $display("FAIL bypass_stored got=%h want=1122", valA);
        end
        tick();
    endtask

    task automatic test_collision();
        dstE = 4'd4; valE = 64'h100; dstM = 4'd4; valM = 64'h200; srcB = 4'd4;
        #4;
        checks++;
        if (valB !== 64'h200) begin
            failures++;
            $display("FAIL collide_bypass got=%h want=200", valB);
        end
        model_write();
        tick();
        idle_ports();
        #4;
        checks++;
        if (valB !== 64'h200) begin
            failures++;
            $display("FAIL collide_stored got=%h want=200", valB);
        end
        tick();
    endtask

    task automatic test_dump();
        for (int i = 0; i < 15; i++) begin
            dstE = 4'(i); valE = 64'(i * 16);
            model_write();
            tick();
        end
        idle_ports();
        run_dump(1'b1, "dump");
    endtask

    task automatic test_nowrite();
        dstE = 4'hF; dstM = 4'hF; valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
        tick();
        idle_ports();
        run_dump(1'b0, "nowrite");
    endtask

    task automatic test_reset_mid_dump();
        bool_wait: begin end
        dump_req = 1'b1; dump_ready = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (dump_valid && dump_idx == 4'd5) break;
            tick();
        end
        checks++;
        if (dump_idx !== 4'd5 || dump_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_reach got=%0d/%b want=5/1", dump_idx, dump_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got=v%b b%b want=00", dump_valid, dump_busy);
        end
        model_reset();
        srcA = 4'd4; srcB = 4'd3;
        #1;
        checks++;
        if (valA !== SPR || valB !== 64'h0) begin
            failures++;
            $display("FAIL midrst_regs got=%h/%h want=%h/0", valA, valB, SPR);
        end
        tick();
        rst = 1'b0;
        dump_ready = 1'b0;
        tick();
        run_dump(1'b1, "restart");
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            dstE = 4'($urandom_range(0, 15));
            dstM = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
            valE = {$urandom, $urandom};
            valM = {$urandom, $urandom};
            srcA = ($urandom_range(0, 1) == 0) ? dstE : 4'($urandom_range(0, 15));
            srcB = ($urandom_range(0, 1) == 0) ? dstM : 4'($urandom_range(0, 15));
            #4;
            checks++;
            if (valA !== ref_read(srcA) || valB !== ref_read(srcB)) begin
                failures++;
                $display("FAIL random c=%0d a=%0d b=%0d got=%h/%h want=%h/%h",
                         c, srcA, srcB, valA, valB, ref_read(srcA), ref_read(srcB));
            end
            model_write();
            tick();
        end
        idle_ports();
        run_dump(1'b0, "final");
    endtask

    initial begin
        rst = 1'b1;
        srcA = 4'hF; srcB = 4'hF;
        idle_ports();
        model_reset();
        #22;
        rst = 1'b0;
        tick();
        test_reset();
        test_bypass();
        test_collision();
        test_dump();
        test_nowrite();
        test_reset_mid_dump();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
